elevator_controller: RTL and testbench

- Sequencing controller for an 8-floor car. Latches hall (up/down) and in-car floor buttons, chooses direction, steps the floor register, and times the door.
- Direction choice uses the same rule as the team's request-solver logic: "is anything pending above / below the current floor". Here that logic is computed internally from registered request state.
- Sits between the button/lamp panel and the motor/door drivers.

---
 rtl/elevator_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_elevator_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_controller.sv
// Sequencing controller for a single elevator car: latches hall and car calls,
// picks a travel direction, steps the floor register and times the door.
module elevator_controller #(
  parameter int unsigned MAX_FLOOR   = 8,
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [MAX_FLOOR-1:0]         upButton,
  input  logic [MAX_FLOOR-1:0]         downButton,
  input  logic [MAX_FLOOR-1:0]         floorButton,
  output logic [$clog2(MAX_FLOOR)-1:0] floor,
  output logic [MAX_FLOOR-1:0]         upRequest,
  output logic [MAX_FLOOR-1:0]         downRequest,
  output logic [MAX_FLOOR-1:0]         floorRequest,
  output logic                         movingUp,
  output logic                         movingDown,
  output logic                         doorOpen
);

  localparam int unsigned FlW    = $clog2(MAX_FLOOR);
  localparam int unsigned CntMax = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [FlW-1:0]       TopFloor = FlW'(MAX_FLOOR - 1);
  localparam logic [CntW-1:0]      MoveLast = CntW'(MOVE_CYCLES - 1);
  localparam logic [CntW-1:0]      DoorLast = CntW'(DOOR_CYCLES - 1);
  localparam logic [MAX_FLOOR-1:0] OneHot0  = MAX_FLOOR'(1);

  typedef enum logic [1:0] {
    StIdle,
    StMoveUp,
    StMoveDown,
    StDoorOpen
  } state_e;

  state_e               state_q, state_d;
  logic [FlW-1:0]       floor_q, floor_d;
  logic [MAX_FLOOR-1:0] up_q, up_d;
  logic [MAX_FLOOR-1:0] dn_q, dn_d;
  logic [MAX_FLOOR-1:0] car_q, car_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 pref_up_q, pref_up_d;
  // Which hall bits were cleared at the current stop; those presses are absorbed
  // while the door stays open.
  logic                 clr_up_q, clr_up_d;
  logic                 clr_dn_q, clr_dn_d;

  // Bits strictly above / strictly below the floor selected by a one-hot vector.
  function automatic logic [MAX_FLOOR-1:0] mask_above(input logic [MAX_FLOOR-1:0] oh);
    return ~((oh << 1) - OneHot0);
  endfunction

  function automatic logic [MAX_FLOOR-1:0] mask_below(input logic [MAX_FLOOR-1:0] oh);
    return oh - OneHot0;
  endfunction

  logic [MAX_FLOOR-1:0] pend;
  logic [MAX_FLOOR-1:0] sel, sel_up, sel_dn;
  logic                 above, below;
  logic                 above_nf_up, below_nf_dn;
  logic                 go_up, go_dn;
  logic                 stop_up, stop_dn;
  logic [FlW-1:0]       nf_up, nf_dn;
  logic [MAX_FLOOR-1:0] set_up, set_dn, set_car;
  logic [MAX_FLOOR-1:0] clr_up_m, clr_dn_m, clr_car_m;

  always_comb begin
    pend   = up_q | dn_q | car_q;
    sel    = OneHot0 << floor_q;
    sel_up = sel << 1;
    sel_dn = sel >> 1;
    nf_up  = floor_q + FlW'(1);
    nf_dn  = floor_q - FlW'(1);

    above       = |(pend & mask_above(sel));
    below       = |(pend & mask_below(sel));
    above_nf_up = |(pend & mask_above(sel_up));
    below_nf_dn = |(pend & mask_below(sel_dn));

    // Direction choice shared by IDLE and door exit: keep the preferred
    // direction while it has work, otherwise take whatever remains.
    go_up = above && (pref_up_q || !below);
    go_dn = !go_up && below;

    stop_up = car_q[nf_up] || up_q[nf_up] || (!above_nf_up && pend[nf_up]) ||
              (nf_up == TopFloor);
    stop_dn = car_q[nf_dn] || dn_q[nf_dn] || (!below_nf_dn && pend[nf_dn]) ||
              (nf_dn == '0);
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    cnt_d     = cnt_q;
    pref_up_d = pref_up_q;
    clr_up_d  = clr_up_q;
    clr_dn_d  = clr_dn_q;
    clr_up_m  = '0;
    clr_dn_m  = '0;
    clr_car_m = '0;

    set_up  = upButton;
    set_dn  = downButton;
    set_car = floorButton;
    if (state_q == StDoorOpen) begin
      set_car = set_car & ~sel;
      if (clr_up_q) set_up = set_up & ~sel;
      if (clr_dn_q) set_dn = set_dn & ~sel;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pend[floor_q]) begin
          state_d   = StDoorOpen;
          clr_up_m  = sel;
          clr_dn_m  = sel;
          clr_car_m = sel;
          clr_up_d  = 1'b1;
          clr_dn_d  = 1'b1;
        end else if (go_up) begin
          state_d   = StMoveUp;
          pref_up_d = 1'b1;
        end else if (go_dn) begin
          state_d   = StMoveDown;
          pref_up_d = 1'b0;
        end
      end

      StMoveUp: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == MoveLast) begin
          cnt_d   = '0;
          floor_d = nf_up;
          if (stop_up) begin
            state_d   = StDoorOpen;
            clr_car_m = sel_up;
            clr_up_m  = sel_up;
            clr_up_d  = 1'b1;
            clr_dn_d  = !above_nf_up;
            if (!above_nf_up) clr_dn_m = sel_up;
          end
        end
      end

      StMoveDown: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == MoveLast) begin
          cnt_d   = '0;
          floor_d = nf_dn;
          if (stop_dn) begin
            state_d   = StDoorOpen;
            clr_car_m = sel_dn;
            clr_dn_m  = sel_dn;
            clr_dn_d  = 1'b1;
            clr_up_d  = !below_nf_dn;
            if (!below_nf_dn) clr_up_m = sel_dn;
          end
        end
      end

      StDoorOpen: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == DoorLast) begin
          cnt_d    = '0;
          clr_up_d = 1'b0;
          clr_dn_d = 1'b0;
          if (go_up) begin
            state_d   = StMoveUp;
            pref_up_d = 1'b1;
          end else if (go_dn) begin
            state_d   = StMoveDown;
            pref_up_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // A clear at a stop wins over a same-cycle press of that bit.
    up_d  = (up_q | set_up) & ~clr_up_m;
    dn_d  = (dn_q | set_dn) & ~clr_dn_m;
    car_d = (car_q | set_car) & ~clr_car_m;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      floor_q   <= '0;
      up_q      <= '0;
      dn_q      <= '0;
      car_q     <= '0;
      cnt_q     <= '0;
      pref_up_q <= 1'b1;
      clr_up_q  <= 1'b0;
      clr_dn_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      car_q     <= car_d;
      cnt_q     <= cnt_d;
      pref_up_q <= pref_up_d;
      clr_up_q  <= clr_up_d;
      clr_dn_q  <= clr_dn_d;
    end
  end

  assign floor        = floor_q;
  assign upRequest    = up_q;
  assign downRequest  = dn_q;
  assign floorRequest = car_q;
  assign movingUp     = (state_q == StMoveUp);
  assign movingDown   = (state_q == StMoveDown);
  assign doorOpen     = (state_q == StDoorOpen);

endmodule

// File: tb/tb_elevator_controller.sv
// Directed self-checking bench for elevator_controller; inputs change and
// outputs are sampled on the falling clock edge.
module tb_elevator_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] upButton, downButton, floorButton;
  logic [2:0] floor;
  logic [7:0] upRequest, downRequest, floorRequest;
  logic       movingUp, movingDown, doorOpen;

  int checks;
  int errors;

  elevator_controller #(
    .MAX_FLOOR  (8),
    .MOVE_CYCLES(4),
    .DOOR_CYCLES(6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upButton    (upButton),
    .downButton  (downButton),
    .floorButton (floorButton),
    .floor       (floor),
    .upRequest   (upRequest),
    .downRequest (downRequest),
    .floorRequest(floorRequest),
    .movingUp    (movingUp),
    .movingDown  (movingDown),
    .doorOpen    (doorOpen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    upButton = '0; downButton = '0; floorButton = 8'hff;
    repeat (2) @(negedge clk);
    checks++; if (floor !== 3'd0) begin errors++; $display("FAIL reset_floor: got %0d want 0", floor); end
    checks++; if ({upRequest, downRequest, floorRequest} !== 24'h0) begin errors++;
      $display("FAIL reset_vectors: got %h/%h/%h want 0", upRequest, downRequest, floorRequest); end
    checks++; if ({movingUp, movingDown, doorOpen} !== 3'b000) begin errors++;
      $display("FAIL reset_outputs: got %b want 000", {movingUp, movingDown, doorOpen}); end
    floorButton = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({movingUp, movingDown, doorOpen, floorRequest} !== 11'h0) begin errors++;
      $display("FAIL reset_release: got %b/%h want idle", {movingUp, movingDown, doorOpen}, floorRequest); end
  endtask

  task automatic test_single_call();
    floorButton = 8'h20;
    @(negedge clk);
    floorButton = '0;
    checks++; if (floorRequest !== 8'h20) begin errors++; $display("FAIL call_latch: got %h want 20", floorRequest); end
    checks++; if (movingUp !== 1'b0) begin errors++; $display("FAIL call_not_yet_moving: got %b want 0", movingUp); end
    @(negedge clk);
    checks++; if (movingUp !== 1'b1 || floor !== 3'd0) begin errors++;
      $display("FAIL call_move_entry: got up=%b floor=%0d want up=1 floor=0", movingUp, floor); end
    repeat (19) @(negedge clk);
    checks++; if (movingUp !== 1'b1 || floor !== 3'd4) begin errors++;
      $display("FAIL call_before_arrive: got up=%b floor=%0d want up=1 floor=4", movingUp, floor); end
    @(negedge clk);
    checks++; if (floor !== 3'd5 || doorOpen !== 1'b1 || movingUp !== 1'b0) begin errors++;
      $display("FAIL call_arrive: got floor=%0d door=%b up=%b want 5/1/0", floor, doorOpen, movingUp); end
    checks++; if (floorRequest !== 8'h00) begin errors++; $display("FAIL call_cleared: got %h want 00", floorRequest); end
    repeat (5) @(negedge clk);
    checks++; if (doorOpen !== 1'b1) begin errors++; $display("FAIL call_door_last: got %b want 1", doorOpen); end
    @(negedge clk);
    checks++; if ({movingUp, movingDown, doorOpen} !== 3'b000) begin errors++;
      $display("FAIL call_idle: got %b want 000", {movingUp, movingDown, doorOpen}); end
  endtask

  // Car at 5 goes to 3 (preferred becomes DOWN), then calls at 1 and 6.
  task automatic test_pref_down();
    floorButton = 8'h08;
    @(negedge clk);
    floorButton = '0;
    @(negedge clk);
    checks++; if (movingDown !== 1'b1) begin errors++; $display("FAIL pref_go_down: got %b want 1", movingDown); end
    repeat (8) @(negedge clk);
    checks++; if (floor !== 3'd3 || doorOpen !== 1'b1) begin errors++;
      $display("FAIL pref_at3: got floor=%0d door=%b want 3/1", floor, doorOpen); end
    repeat (6) @(negedge clk);
    floorButton = 8'h42;
    @(negedge clk);
    floorButton = '0;
    checks++; if (floorRequest !== 8'h42 || movingDown !== 1'b0) begin errors++;
      $display("FAIL pref_latch: got %h dn=%b want 42/0", floorRequest, movingDown); end
    @(negedge clk);
    checks++; if (movingDown !== 1'b1 || movingUp !== 1'b0) begin errors++;
      $display("FAIL pref_choose_down: got dn=%b up=%b want 1/0", movingDown, movingUp); end
    repeat (8) @(negedge clk);
    checks++; if (floor !== 3'd1 || doorOpen !== 1'b1 || floorRequest !== 8'h40) begin errors++;
      $display("FAIL pref_at1: got floor=%0d door=%b req=%h want 1/1/40", floor, doorOpen, floorRequest); end
    repeat (6) @(negedge clk);
    checks++; if (movingUp !== 1'b1 || floor !== 3'd1) begin errors++;
      $display("FAIL pref_reverse: got up=%b floor=%0d want 1/1", movingUp, floor); end
    repeat (20) @(negedge clk);
    checks++; if (floor !== 3'd6 || doorOpen !== 1'b1 || floorRequest !== 8'h00) begin errors++;
      $display("FAIL pref_at6: got floor=%0d door=%b req=%h want 6/1/00", floor, doorOpen, floorRequest); end
    repeat (6) @(negedge clk);
    checks++; if ({movingUp, movingDown, doorOpen} !== 3'b000) begin errors++;
      $display("FAIL pref_idle: got %b want 000", {movingUp, movingDown, doorOpen}); end
  endtask

  task automatic test_hall_pair();
    do_reset();
    upButton = 8'h08; downButton = 8'h08;
    @(negedge clk);
    upButton = '0; downButton = '0;
    checks++; if (upRequest !== 8'h08 || downRequest !== 8'h08) begin errors++;
      $display("FAIL hall_latch: got up=%h dn=%h want 08/08", upRequest, downRequest); end
    @(negedge clk);
    checks++; if (movingUp !== 1'b1) begin errors++; $display("FAIL hall_move_up: got %b want 1", movingUp); end
    repeat (12) @(negedge clk);
    checks++; if (floor !== 3'd3 || doorOpen !== 1'b1) begin errors++;
      $display("FAIL hall_stop3: got floor=%0d door=%b want 3/1", floor, doorOpen); end
    checks++; if (upRequest !== 8'h00 || downRequest !== 8'h00) begin errors++;
      $display("FAIL hall_both_clear: got up=%h dn=%h want 00/00", upRequest, downRequest); end
    repeat (6) @(negedge clk);
    checks++; if ({movingUp, movingDown, doorOpen} !== 3'b000) begin errors++;
      $display("FAIL hall_idle: got %b want 000", {movingUp, movingDown, doorOpen}); end
  endtask

  // From 3 to 4, then press the car button for 4 while the door is open.
  task automatic test_absorb();
    floorButton = 8'h10;
    @(negedge clk);
    floorButton = '0;
    repeat (5) @(negedge clk);
    checks++; if (floor !== 3'd4 || doorOpen !== 1'b1) begin errors++;
      $display("FAIL absorb_at4: got floor=%0d door=%b want 4/1", floor, doorOpen); end
    repeat (2) @(negedge clk);
    floorButton = 8'h10;
    @(negedge clk);
    floorButton = '0;
    checks++; if (floorRequest !== 8'h00 || doorOpen !== 1'b1) begin errors++;
      $display("FAIL absorb_not_latched: got req=%h door=%b want 00/1", floorRequest, doorOpen); end
    repeat (2) @(negedge clk);
    checks++; if (doorOpen !== 1'b1) begin errors++; $display("FAIL absorb_door6: got %b want 1", doorOpen); end
    @(negedge clk);
    checks++; if (doorOpen !== 1'b0) begin errors++; $display("FAIL absorb_close: got %b want 0", doorOpen); end
    @(negedge clk);
    checks++; if ({movingUp, movingDown, doorOpen, floorRequest} !== 11'h0) begin errors++;
      $display("FAIL absorb_no_reopen: got %b/%h want idle", {movingUp, movingDown, doorOpen}, floorRequest); end
  endtask

  // Car call to 6; hall up+down at 2 pressed while the car sits at floor 1.
  task automatic test_pass_hall();
    do_reset();
    floorButton = 8'h40;
    @(negedge clk);
    floorButton = '0;
    repeat (5) @(negedge clk);
    checks++; if (floor !== 3'd1 || movingUp !== 1'b1) begin errors++;
      $display("FAIL pass_at1: got floor=%0d up=%b want 1/1", floor, movingUp); end
    upButton = 8'h04; downButton = 8'h04;
    @(negedge clk);
    upButton = '0; downButton = '0;
    checks++; if (upRequest !== 8'h04 || downRequest !== 8'h04) begin errors++;
      $display("FAIL pass_latch: got up=%h dn=%h want 04/04", upRequest, downRequest); end
    repeat (3) @(negedge clk);
    checks++; if (floor !== 3'd2 || doorOpen !== 1'b1) begin errors++;
      $display("FAIL pass_stop2: got floor=%0d door=%b want 2/1", floor, doorOpen); end
    checks++; if (upRequest !== 8'h00 || downRequest !== 8'h04 || floorRequest !== 8'h40) begin errors++;
      $display("FAIL pass_partial_clear: got %h/%h/%h want 00/04/40", upRequest, downRequest, floorRequest); end
    repeat (6) @(negedge clk);
    checks++; if (movingUp !== 1'b1) begin errors++; $display("FAIL pass_continue_up: got %b want 1", movingUp); end
    repeat (16) @(negedge clk);
    checks++; if (floor !== 3'd6 || doorOpen !== 1'b1 || downRequest !== 8'h04) begin errors++;
      $display("FAIL pass_at6: got floor=%0d door=%b dn=%h want 6/1/04", floor, doorOpen, downRequest); end
    repeat (6) @(negedge clk);
    checks++; if (movingDown !== 1'b1) begin errors++; $display("FAIL pass_reverse: got %b want 1", movingDown); end
    repeat (16) @(negedge clk);
    checks++; if (floor !== 3'd2 || doorOpen !== 1'b1 || downRequest !== 8'h00) begin errors++;
      $display("FAIL pass_back2: got floor=%0d door=%b dn=%h want 2/1/00", floor, doorOpen, downRequest); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_motion();
    floorButton = 8'h20;
    @(negedge clk);
    floorButton = '0;
    repeat (3) @(negedge clk);
    checks++; if (movingUp !== 1'b1 || floor !== 3'd2) begin errors++;
      $display("FAIL rstmid_moving: got up=%b floor=%0d want 1/2", movingUp, floor); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (floor !== 3'd0 || {movingUp, movingDown, doorOpen} !== 3'b000) begin errors++;
      $display("FAIL rstmid_state: got floor=%0d out=%b want 0/000", floor, {movingUp, movingDown, doorOpen}); end
    checks++; if ({upRequest, downRequest, floorRequest} !== 24'h0) begin errors++;
      $display("FAIL rstmid_vectors: got %h/%h/%h want 0", upRequest, downRequest, floorRequest); end
    repeat (3) @(negedge clk);
    checks++; if (floor !== 3'd0 || {movingUp, movingDown, doorOpen} !== 3'b000) begin errors++;
      $display("FAIL rstmid_stays_idle: got floor=%0d out=%b want 0/000", floor, {movingUp, movingDown, doorOpen}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    upButton = '0; downButton = '0; floorButton = '0;
    test_reset();
    test_single_call();
    test_pref_down();
    test_hall_pair();
    test_absorb();
    test_pass_hall();
    test_reset_mid_motion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
